// File: rtl/qblock_item_arbiter.sv
// qblock_item_arbiter: Q-block item roulette shared by two cars, one held item per car, item use (boost window / fire pulse).
// Latency: collision sampled at edge t -> roulette from t+2 -> item in slot from t+3+ROLL_FRAMES; use acts at the next edge.
// Backpressure: none; collisions on a full, pending or rolling car are dropped, and a use on an empty slot is dropped.
// Build option: define QBLOCK_BOOST_STACK_EN so a BOOST used during an active boost adds time (saturating) instead of reloading.
module qblock_item_arbiter #(
  parameter int unsigned ROLL_FRAMES  = 30,
  parameter int unsigned BOOST_FRAMES = 60,
  parameter int unsigned TIMER_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       i_render_clk,
  input  logic       i_rst_n,
  input  logic       i_car1_collision,
  input  logic       i_car2_collision,
  input  logic       i_car1_use,
  input  logic       i_car2_use,
  output logic [1:0] o_car1_item,
  output logic [1:0] o_car2_item,
  output logic       o_car1_boost,
  output logic       o_car2_boost,
  output logic       o_car1_fire,
  output logic       o_car2_fire,
  output logic [1:0] o_fire_item,
  output logic [1:0] o_rolling
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROLL  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam logic [1:0]         ITEM_NONE  = 2'd0;
  localparam logic [1:0]         ITEM_BOOST = 2'd1;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0]        LFSR_TAPS  = 16'hB400;
  localparam logic [TIMER_W-1:0] ROLL_LAST  = TIMER_W'(ROLL_FRAMES - 1);
`ifdef QBLOCK_BOOST_STACK_EN
  localparam logic [TIMER_W:0]   BOOST_ADD  = (TIMER_W + 1)'(BOOST_FRAMES);
  localparam logic [TIMER_W:0]   BOOST_CAP  = (TIMER_W + 1)'(2 * BOOST_FRAMES);
`else
  localparam logic [TIMER_W-1:0] BOOST_LD   = TIMER_W'(BOOST_FRAMES);
`endif

  // Car index 0 is car 1, index 1 is car 2 throughout.
  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;        // roulette owner
  logic                    rr_q, rr_d;              // car favoured when both are pending
  logic [TIMER_W-1:0]      roll_cnt_q, roll_cnt_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [1:0]              hit_q, hit_d;            // qualified collision, one stage before pend
  logic [1:0]              pend_q, pend_d;
  logic [1:0][1:0]         slot_q, slot_d;
  logic [1:0][TIMER_W-1:0] boost_q, boost_d;
  logic [1:0]              fire_q, fire_d;
  logic [1:0]              fire_item_q, fire_item_d;

  logic [1:0] collision;
  logic [1:0] use_req;
  logic [1:0] owned;
  logic [1:0] grant_item;
  logic       grant;
  logic       arb_vld;
  logic       arb_ptr;
  logic       arb_pick;

  assign collision = {i_car2_collision, i_car1_collision};
  assign use_req   = {i_car2_use, i_car1_use};

  // A car owns the roulette from its first ROLL cycle through its GRANT cycle.
  assign owned[0] = (state_q != ST_IDLE) && !owner_q;
  assign owned[1] = (state_q != ST_IDLE) &&  owner_q;

  assign grant_item = (lfsr_q[1:0] == 2'd0) ? ITEM_BOOST : lfsr_q[1:0];

  // GRANT arbitrates with the pointer already flipped, so a waiting car rolls with no idle gap.
  assign arb_ptr  = (state_q == ST_GRANT) ? ~owner_q : rr_q;
  assign arb_vld  = |pend_q;
  assign arb_pick = (&pend_q) ? arb_ptr : pend_q[1];

  // Free-running item LFSR.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // Qualify collisions against the pre-edge slot, pend and roulette state.
  always_comb begin
    hit_d = '0;
    for (int n = 0; n < 2; n++) begin
      hit_d[n] = collision[n] && (slot_q[n] == ITEM_NONE) && !pend_q[n] && !hit_q[n] && !owned[n];
    end
  end

  // Roulette FSM: pick a pending car, count the roll, grant.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    roll_cnt_d = roll_cnt_q;
    pend_d     = pend_q | hit_q;
    grant      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d          = ST_ROLL;
          owner_d          = arb_pick;
          roll_cnt_d       = '0;
          pend_d[arb_pick] = 1'b0;
        end
      end
      ST_ROLL: begin
        if (roll_cnt_q == ROLL_LAST) begin
          state_d    = ST_GRANT;
          roll_cnt_d = '0;
        end else begin
          roll_cnt_d = roll_cnt_q + TIMER_W'(1);
        end
      end
      ST_GRANT: begin
        grant = 1'b1;
        rr_d  = ~owner_q;
        if (arb_vld) begin
          state_d          = ST_ROLL;
          owner_d          = arb_pick;
          roll_cnt_d       = '0;
          pend_d[arb_pick] = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef QBLOCK_BOOST_STACK_EN
  logic [1:0][TIMER_W:0] boost_sum;

  // Extended boost time before saturation.
  always_comb begin
    boost_sum = '0;
    for (int n = 0; n < 2; n++) begin
      boost_sum[n] = {1'b0, boost_q[n]} + BOOST_ADD;
    end
  end
`endif

  // Item slots, boost timers and fire pulses.
  always_comb begin
    slot_d      = slot_q;
    boost_d     = boost_q;
    fire_d      = '0;
    fire_item_d = '0;
    for (int n = 0; n < 2; n++) begin
      if (boost_q[n] != '0) begin
        boost_d[n] = boost_q[n] - TIMER_W'(1);
      end
      if (use_req[n] && (slot_q[n] != ITEM_NONE)) begin
        slot_d[n] = ITEM_NONE;
        if (slot_q[n] == ITEM_BOOST) begin
`ifdef QBLOCK_BOOST_STACK_EN
          boost_d[n] = (boost_sum[n] > BOOST_CAP) ? BOOST_CAP[TIMER_W-1:0] : boost_sum[n][TIMER_W-1:0];
`else
          boost_d[n] = BOOST_LD;
`endif
        end else begin
          fire_d[n] = 1'b1;
        end
      end
    end
    // The owner's slot is empty while it rolls, so a grant never collides with a use.
    if (grant) begin
      slot_d[owner_q] = grant_item;
    end
    // Car 1 wins the shared item bus when both fire together.
    if (fire_d[0]) begin
      fire_item_d = slot_q[0];
    end else if (fire_d[1]) begin
      fire_item_d = slot_q[1];
    end
  end

  // State registers; reset abandons any roll and drops pending requests.
  always_ff @(posedge i_render_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      roll_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      hit_q       <= '0;
      pend_q      <= '0;
      slot_q      <= '0;
      boost_q     <= '0;
      fire_q      <= '0;
      fire_item_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      roll_cnt_q  <= roll_cnt_d;
      lfsr_q      <= lfsr_d;
      hit_q       <= hit_d;
      pend_q      <= pend_d;
      slot_q      <= slot_d;
      boost_q     <= boost_d;
      fire_q      <= fire_d;
      fire_item_q <= fire_item_d;
    end
  end

  assign o_car1_item  = slot_q[0];
  assign o_car2_item  = slot_q[1];
  assign o_car1_boost = (boost_q[0] != '0);
  assign o_car2_boost = (boost_q[1] != '0);
  assign o_car1_fire  = fire_q[0];
  assign o_car2_fire  = fire_q[1];
  assign o_fire_item  = fire_item_q;
  assign o_rolling    = (state_q == ST_ROLL) ? (owner_q ? 2'd2 : 2'd1) : 2'd0;

endmodule

// File: tb/tb_qblock_item_arbiter.sv
// tb_qblock_item_arbiter: scoreboarded bench for the Q-block item arbiter.
// Item grants and fire pulses are predicted when stimulus is driven and matched when the DUT produces them.
// Boost windows, roll windows and reset behaviour are checked directly against bench-computed values.
module tb_qblock_item_arbiter;

  localparam int          R    = 30;
  localparam int          B    = 60;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c1_col = 1'b0, c2_col = 1'b0, c1_use = 1'b0, c2_use = 1'b0;
  logic [1:0] c1_item, c2_item, fire_item, rolling;
  logic       c1_boost, c2_boost, c1_fire, c2_fire;

  qblock_item_arbiter #(
    .ROLL_FRAMES (R),
    .BOOST_FRAMES(B),
    .TIMER_W     (8),
    .LFSR_SEED   (SEED)
  ) dut (
    .i_render_clk    (clk),
    .i_rst_n         (rst_n),
    .i_car1_collision(c1_col),
    .i_car2_collision(c2_col),
    .i_car1_use      (c1_use),
    .i_car2_use      (c2_use),
    .o_car1_item     (c1_item),
    .o_car2_item     (c2_item),
    .o_car1_boost    (c1_boost),
    .o_car2_boost    (c2_boost),
    .o_car1_fire     (c1_fire),
    .o_car2_fire     (c2_fire),
    .o_fire_item     (fire_item),
    .o_rolling       (rolling)
  );

  always #5 clk = ~clk;

  typedef struct {
    int item;
    int cyc;
  } exp_t;

  exp_t slot_sb1[$], slot_sb2[$], fire_sb1[$], fire_sb2[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   held_m[2];
  int   cyc = 0;
  logic [15:0] lfsr_m = SEED;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int k);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = lfsr_next(r);
    return r;
  endfunction

  function automatic int item_of(input logic [15:0] v);
    return (v[1:0] == 2'd0) ? 1 : int'(v[1:0]);
  endfunction

  function automatic int slot_of(input int car);
    return (car == 1) ? int'(c1_item) : int'(c2_item);
  endfunction

  function automatic int boost_of(input int car);
    return (car == 1) ? int'(c1_boost) : int'(c2_boost);
  endfunction

  // Edge counter and reference LFSR.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else        lfsr_m <= lfsr_next(lfsr_m);
  end

  // Output monitor: match new items and fire pulses against the scoreboards.
  logic [1:0] prev1 = 2'd0, prev2 = 2'd0;
  exp_t       e_mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev1 <= 2'd0;
      prev2 <= 2'd0;
    end else begin
      if (prev1 == 2'd0 && c1_item != 2'd0) begin
        chk("c1_slot_expected", int'(slot_sb1.size() > 0), 1);
        if (slot_sb1.size() > 0) begin
          e_mon = slot_sb1.pop_front();
          chk("c1_item", int'(c1_item), e_mon.item);
          chk("c1_item_cycle", cyc, e_mon.cyc);
        end
      end
      if (prev2 == 2'd0 && c2_item != 2'd0) begin
        chk("c2_slot_expected", int'(slot_sb2.size() > 0), 1);
        if (slot_sb2.size() > 0) begin
          e_mon = slot_sb2.pop_front();
          chk("c2_item", int'(c2_item), e_mon.item);
          chk("c2_item_cycle", cyc, e_mon.cyc);
        end
      end
      if (c1_fire) begin
        chk("c1_fire_expected", int'(fire_sb1.size() > 0), 1);
        if (fire_sb1.size() > 0) begin
          e_mon = fire_sb1.pop_front();
          chk("c1_fire_item", int'(fire_item), e_mon.item);
          chk("c1_fire_cycle", cyc, e_mon.cyc);
        end
      end
      if (c2_fire) begin
        chk("c2_fire_expected", int'(fire_sb2.size() > 0), 1);
        if (fire_sb2.size() > 0) begin
          e_mon = fire_sb2.pop_front();
          chk("c2_fire_cycle", cyc, e_mon.cyc);
          if (!c1_fire) chk("c2_fire_item", int'(fire_item), e_mon.item);
        end
      end
      prev1 <= c1_item;
      prev2 <= c2_item;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_slot(input int car, input int item, input int at);
    exp_t e;
    e.item = item;
    e.cyc  = at;
    if (car == 1) slot_sb1.push_back(e);
    else          slot_sb2.push_back(e);
    held_m[car-1] = item;
  endtask

  // Wait for an LFSR alignment that yields `want` (0 = any), touch the block, wait for the item.
  task automatic get_item(input int car, input int want);
    int i;
    int it;
    i  = 0;
    it = item_of(lfsr_adv(lfsr_m, 3 + R));
    while (want != 0 && it != want && i < 500) begin
      tick();
      i++;
      it = item_of(lfsr_adv(lfsr_m, 3 + R));
    end
    push_slot(car, it, cyc + 4 + R);
    if (car == 1) c1_col = 1'b1; else c2_col = 1'b1;
    tick();
    c1_col = 1'b0;
    c2_col = 1'b0;
    i = 0;
    while (slot_of(car) == 0 && i < 3 * R) begin
      tick();
      i++;
    end
    chk("slot_arrived", int'(slot_of(car) != 0), 1);
  endtask

  task automatic use_item(input int car);
    exp_t e;
    e.item = held_m[car-1];
    e.cyc  = cyc + 1;
    if (e.item == 2 || e.item == 3) begin
      if (car == 1) fire_sb1.push_back(e);
      else          fire_sb2.push_back(e);
    end
    held_m[car-1] = 0;
    if (car == 1) c1_use = 1'b1; else c2_use = 1'b1;
    tick();
    c1_use = 1'b0;
    c2_use = 1'b0;
    chk("slot_cleared", slot_of(car), 0);
  endtask

  task automatic boost_len(input int car, output int n);
    n = 0;
    while (boost_of(car) != 0 && n < 300) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int c0, n, e1, rem, exp_len, exp_roll;
    exp_t e;
    held_m[0] = 0;
    held_m[1] = 0;

    // Reset state, inside and just after reset.
    repeat (3) tick();
    chk("rst_c1_item", int'(c1_item), 0);
    chk("rst_c2_item", int'(c2_item), 0);
    chk("rst_rolling", int'(rolling), 0);
    chk("rst_boost", int'({c1_boost, c2_boost}), 0);
    chk("rst_fire", int'({c1_fire, c2_fire, fire_item}), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rolling", int'(rolling), 0);

    // Single car-1 roll: roulette window and grant timing.
    c0 = cyc;
    push_slot(1, item_of(lfsr_adv(lfsr_m, 3 + R)), c0 + 4 + R);
    c1_col = 1'b1;
    tick();
    c1_col = 1'b0;
    while (cyc <= c0 + R + 4) begin
      exp_roll = (cyc >= c0 + 3 && cyc <= c0 + 2 + R) ? 1 : 0;
      chk("t1_rolling", int'(rolling), exp_roll);
      tick();
    end
    chk("t1_c1_item", int'(c1_item), held_m[0]);
    chk("t1_c2_item", int'(c2_item), 0);

    // Spend it; a boost must last exactly B frames and then stay at zero.
    n = held_m[0];
    use_item(1);
    if (n == 1) begin
      boost_len(1, n);
      chk("t1_boost_len", n, B);
    end
    repeat (B + 5) tick();
    chk("boost_no_underflow", int'(c1_boost), 0);

    // Reset in the middle of a roll.
    c0 = cyc;
    c1_col = 1'b1;
    tick();
    c1_col = 1'b0;
    repeat (16) tick();
    chk("pre_rst_rolling", int'(rolling), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rolling", int'(rolling), 0);
    chk("mid_rst_items", int'({c1_item, c2_item}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3 * R) tick();
    chk("after_rst_c1_item", int'(c1_item), 0);
    chk("after_rst_rolling", int'(rolling), 0);

    // Both cars touch together after reset: car 1 first, car 2 straight after GRANT.
    c0 = cyc;
    push_slot(1, item_of(lfsr_adv(lfsr_m, 3 + R)), c0 + 4 + R);
    push_slot(2, item_of(lfsr_adv(lfsr_m, 4 + 2 * R)), c0 + 5 + 2 * R);
    c1_col = 1'b1;
    c2_col = 1'b1;
    tick();
    c1_col = 1'b0;
    c2_col = 1'b0;
    while (cyc <= c0 + 2 * R + 6) begin
      exp_roll = (cyc >= c0 + 3 && cyc <= c0 + 2 + R) ? 1 :
                 (cyc >= c0 + 4 + R && cyc <= c0 + 3 + 2 * R) ? 2 : 0;
      chk("both_rolling", int'(rolling), exp_roll);
      tick();
    end
    use_item(1);
    use_item(2);
    repeat (B + 5) tick();

    // Boost re-use while active: reload, or stack with saturation.
    get_item(1, 1);
    use_item(1);
    e1 = cyc;
    chk("stk_boost_on", int'(c1_boost), 1);
    get_item(1, 1);
    while (cyc < e1 + 40) tick();
    rem = (cyc - e1 < B) ? B - (cyc - e1) : 0;
`ifdef QBLOCK_BOOST_STACK_EN
    exp_len = (rem + B > 2 * B) ? 2 * B : rem + B;
`else
    exp_len = B;
`endif
    chk("stk_pre_use", int'(c1_boost), int'(rem > 0));
    chk("stk_c2_boost_idle", int'(c2_boost), 0);
    use_item(1);
    boost_len(1, n);
    chk("stk_boost_len", n, exp_len);

    // Car 2 SHELL: single fire pulse, then a use on an empty slot does nothing.
    get_item(2, 2);
    use_item(2);
    tick();
    chk("c2_fire_width", int'(c2_fire), 0);
    use_item(2);
    chk("c2_fire_empty", int'(c2_fire), 0);

    // Both cars fire in the same cycle: car 1's item is shown.
    get_item(1, 3);
    get_item(2, 2);
    e.item = 3; e.cyc = cyc + 1; fire_sb1.push_back(e);
    e.item = 2; e.cyc = cyc + 1; fire_sb2.push_back(e);
    held_m[0] = 0;
    held_m[1] = 0;
    c1_use = 1'b1;
    c2_use = 1'b1;
    tick();
    c1_use = 1'b0;
    c2_use = 1'b0;
    chk("dual_fire", int'({c1_fire, c2_fire}), 3);
    chk("dual_fire_item", int'(fire_item), 3);

    // Collision held for 100 frames while holding an item.
    get_item(1, 0);
    n = 0;
    c1_col = 1'b1;
    repeat (100) begin
      tick();
      if (rolling != 2'd0) n++;
    end
    c1_col = 1'b0;
    chk("hold_roll_cycles", n, 0);
    chk("hold_slot", int'(c1_item), held_m[0]);

    // Use and collision in the same cycle: slot empties, collision ignored.
    c1_col = 1'b1;
    use_item(1);
    c1_col = 1'b0;
    n = 0;
    repeat (3 * R) begin
      tick();
      if (rolling != 2'd0) n++;
    end
    chk("usecol_roll_cycles", n, 0);
    chk("usecol_slot", int'(c1_item), 0);

    repeat (B + 5) tick();
    chk("sb_slot1_empty", slot_sb1.size(), 0);
    chk("sb_slot2_empty", slot_sb2.size(), 0);
    chk("sb_fire1_empty", fire_sb1.size(), 0);
    chk("sb_fire2_empty", fire_sb2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
